// File: rtl/flag_register_pkg.sv
// Shared CPU status-flag definitions: bit positions used when the flags are
// packed into a status word, plus a helper that performs that packing.
package flag_register_pkg;

  localparam int NUM_FLAGS = 3;

  localparam int FLAG_C = 0;
  localparam int FLAG_Z = 1;
  localparam int FLAG_B = 2;

  typedef logic [NUM_FLAGS-1:0] status_word_t;

  function automatic status_word_t pack_flags(input logic c, input logic z, input logic b);
    status_word_t word;
    word         = '0;
    word[FLAG_C] = c;
    word[FLAG_Z] = z;
    word[FLAG_B] = b;
    return word;
  endfunction

endpackage

// File: rtl/flag_register_bit.sv
// One status flag: a 1-bit register with synchronous active-low reset
// and a load enable.
module flag_register_bit (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  // NOTE: reset is sampled only on the clock edge and wins over the load;
  // non-blocking assignment keeps all three flags updating in lockstep.
  always_ff @(posedge clk) begin
    if (!rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/flag_register.sv
// Processor status flag register: Carry and Borrow load on flag_cb_valid,
// Zero loads every cycle; all outputs come straight from registers.
module flag_register
  import flag_register_pkg::*;
(
  input  logic clk,
  input  logic flag_rst,
  input  logic flag_cb_valid,
  input  logic flag_c_in,
  input  logic flag_z_in,
  input  logic flag_b_in,
  output logic flag_c,
  output logic flag_z,
  output logic flag_b
);

  status_word_t flag_d;
  status_word_t flag_en;
  status_word_t flag_q;

  assign flag_d = pack_flags(flag_c_in, flag_z_in, flag_b_in);

  // Zero is refreshed every cycle; Carry/Borrow only when the ALU vouches for them.
  assign flag_en = pack_flags(flag_cb_valid, 1'b1, flag_cb_valid);

  for (genvar i = 0; i < NUM_FLAGS; i++) begin : g_flag
    flag_register_bit u_bit (
      .clk (clk),
      .rst (flag_rst),
      .en  (flag_en[i]),
      .d   (flag_d[i]),
      .q   (flag_q[i])
    );
  end

  assign flag_c = flag_q[FLAG_C];
  assign flag_z = flag_q[FLAG_Z];
  assign flag_b = flag_q[FLAG_B];

endmodule

// File: tb/tb_flag_register.sv
// Self-checking bench for flag_register: directed plan followed by random
// cycles, compared against a per-flag behavioural model.
module tb_flag_register;

  logic clk = 1'b0;
  logic flag_rst = 1'b0;
  logic flag_cb_valid = 1'b0;
  logic flag_c_in = 1'b0;
  logic flag_z_in = 1'b0;
  logic flag_b_in = 1'b0;
  logic flag_c, flag_z, flag_b;

  int checks = 0;
  int failures = 0;
  int cycle_no = 0;

  // Model: named flag values, indexed 0=C 1=Z 2=B.
  bit model_flag [3];

  always #5 clk = ~clk;

  flag_register dut (
    .clk           (clk),
    .flag_rst      (flag_rst),
    .flag_cb_valid (flag_cb_valid),
    .flag_c_in     (flag_c_in),
    .flag_z_in     (flag_z_in),
    .flag_b_in     (flag_b_in),
    .flag_c        (flag_c),
    .flag_z        (flag_z),
    .flag_b        (flag_b)
  );

  task automatic check(input string tag, input logic observed, input logic expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%b expected=%b", tag, cycle_no, observed, expected);
    end
  endtask

  // Apply one cycle of inputs at the falling edge, clock it, update the
  // model from the stated rules, then compare at the next falling edge.
  task automatic step(input string tag, input bit rst, input bit valid,
                      input bit c, input bit z, input bit b);
    flag_rst      = rst;
    flag_cb_valid = valid;
    flag_c_in     = c;
    flag_z_in     = z;
    flag_b_in     = b;
    @(posedge clk);
    cycle_no++;
    if (!rst) begin
      foreach (model_flag[i]) model_flag[i] = 1'b0;
    end else begin
      model_flag[1] = z;
      if (valid) begin
        model_flag[0] = c;
        model_flag[2] = b;
      end
    end
    @(negedge clk);
    check({tag, ".c"}, flag_c, model_flag[0]);
    check({tag, ".z"}, flag_z, model_flag[1]);
    check({tag, ".b"}, flag_b, model_flag[2]);
  endtask

  initial begin
    @(negedge clk);

    // Reset held low with every input high: flags read 0 throughout.
    repeat (2) step("reset", 0, 1, 1, 1, 1);

    // Carry pulse: two cycles high, then low.
    repeat (2) step("carry_hi", 1, 1, 1, 0, 0);
    repeat (2) step("carry_lo", 1, 1, 0, 0, 0);

    // Borrow pulse.
    repeat (2) step("borrow_hi", 1, 1, 0, 0, 1);
    repeat (2) step("borrow_lo", 1, 1, 0, 0, 0);

    // Valid gating: C/B hold while Z toggles.
    step("gate_set", 1, 1, 1, 0, 1);
    step("gate_hold0", 1, 0, 0, 1, 0);
    step("gate_hold1", 1, 0, 0, 0, 0);
    step("gate_hold2", 1, 0, 0, 1, 0);

    // Reset mid-operation with loads pending, then release.
    repeat (5) step("midop_load", 1, 1, 1, 0, 1);
    repeat (5) step("midop_rst", 0, 1, 1, 1, 1);
    step("midop_release", 1, 1, 1, 0, 1);

    // Simultaneous C, Z and B.
    step("clear_all", 1, 1, 0, 0, 0);
    step("simultaneous", 1, 1, 1, 1, 1);

    // Random traffic with occasional reset.
    for (int n = 0; n < 300; n++) begin
      step("random", ($urandom_range(0, 15) != 0), 1'($urandom),
           1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
